// File: rtl/serdes_link_pkg.sv
// Shared types and helpers for the SERDES word-alignment engine.
// Lane FSM encoding, counter sizing and packed-bus lane slicing.
package serdes_link_pkg;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } lane_state_e;

  localparam int STATE_W = 3;

  // Bits needed to hold the values 0..max_val (never narrower than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/serdes_link_lane.sv
// One SERDES lane: training-word TX register, BITSLIP alignment FSM,
// lock detection and a saturating error counter for the locked phase.
module serdes_link_lane
  import serdes_link_pkg::*;
#(
  parameter int             DATA_WIDTH    = 8,
  parameter logic [7:0]     TRAIN_PATTERN = 8'h2C,
  parameter int             SLIP_WAIT     = 4,
  parameter int             MATCH_COUNT   = 16,
  parameter int             MAX_SLIPS     = DATA_WIDTH,
  parameter int             ERR_WIDTH     = 16
) (
  input  logic                  CLKDIV,
  input  logic                  RST,
  input  logic                  restart,
  input  logic                  err_inject,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  bitslip,
  output logic                  locked,
  output logic                  fail,
  output logic [ERR_WIDTH-1:0]  err_count,
  output lane_state_e           state_dbg
);

  localparam int WAIT_W  = cnt_width(SLIP_WAIT);
  localparam int SLIP_W  = cnt_width(MAX_SLIPS);
  localparam int MATCH_W = cnt_width(MATCH_COUNT);

  localparam logic [DATA_WIDTH-1:0] TRAIN      = TRAIN_PATTERN[DATA_WIDTH-1:0];
  localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);
  localparam logic [SLIP_W-1:0]     SLIP_MAX   = SLIP_W'(MAX_SLIPS);
  localparam logic [MATCH_W-1:0]    MATCH_LAST = MATCH_W'(MATCH_COUNT - 1);

  lane_state_e          state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [SLIP_W-1:0]    slip_q, slip_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic                 rx_match;

  assign rx_match  = (rx_data == TRAIN);
  assign state_dbg = state_q;
  assign err_count = err_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    slip_d  = slip_q;
    match_d = match_q;
    err_d   = err_q;
    case (state_q)
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_CHECK: begin
        if (rx_match) begin
          match_d = match_q + MATCH_W'(1);
          if (match_q == MATCH_LAST) state_d = ST_LOCKED;
        end else if (slip_q == SLIP_MAX) begin
          state_d = ST_FAIL;
        end else begin
          match_d = '0;
          state_d = ST_SLIP;
        end
      end
      ST_SLIP: begin
        slip_d  = slip_q + SLIP_W'(1);
        state_d = ST_WAIT;
      end
      ST_LOCKED: begin
        if (!rx_match && (err_q != '1)) err_d = err_q + ERR_WIDTH'(1);
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_WAIT;
    endcase
    // Restart wins over every state transition and wipes all lane history.
    if (restart) begin
      state_d = ST_WAIT;
      wait_d  = '0;
      slip_d  = '0;
      match_d = '0;
      err_d   = '0;
    end
  end

  // Outputs decode the current state one cycle late, so a SLIP cycle
  // yields exactly one BITSLIP pulse even if a restart lands on it.
  always_ff @(posedge CLKDIV) begin
    if (RST) begin
      state_q <= ST_WAIT;
      wait_q  <= '0;
      slip_q  <= '0;
      match_q <= '0;
      err_q   <= '0;
      tx_data <= TRAIN;
      bitslip <= 1'b0;
      locked  <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      slip_q  <= slip_d;
      match_q <= match_d;
      err_q   <= err_d;
      tx_data <= TRAIN ^ DATA_WIDTH'(err_inject);
      bitslip <= (state_q == ST_SLIP);
      locked  <= (state_q == ST_LOCKED);
      fail    <= (state_q == ST_FAIL);
    end
  end

endmodule

// File: rtl/serdes_link_aligner.sv
// Multi-lane OSERDES/ISERDES loopback aligner: one lane engine per channel
// plus a registered all-lanes-locked flag. Lane FSM states exported on STATE_DBG.
module serdes_link_aligner
  import serdes_link_pkg::*;
#(
  parameter int         NUM_CHANNELS  = 4,
  parameter int         DATA_WIDTH    = 8,
  parameter logic [7:0] TRAIN_PATTERN = 8'h2C,
  parameter int         SLIP_WAIT     = 4,
  parameter int         MATCH_COUNT   = 16,
  parameter int         MAX_SLIPS     = DATA_WIDTH,
  parameter int         ERR_WIDTH     = 16
) (
  input  logic                               CLKDIV,
  input  logic                               RST,
  input  logic                               RESTART,
  input  logic [NUM_CHANNELS-1:0]            ERR_INJECT,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] TX_DATA,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] RX_DATA,
  output logic [NUM_CHANNELS-1:0]            BITSLIP,
  output logic [NUM_CHANNELS-1:0]            LOCKED,
  output logic [NUM_CHANNELS-1:0]            FAIL,
  output logic                               ALL_LOCKED,
  output logic [NUM_CHANNELS*ERR_WIDTH-1:0]  ERR_COUNT,
  output logic [NUM_CHANNELS*STATE_W-1:0]    STATE_DBG
);

  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_lane
    serdes_link_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .TRAIN_PATTERN(TRAIN_PATTERN),
      .SLIP_WAIT    (SLIP_WAIT),
      .MATCH_COUNT  (MATCH_COUNT),
      .MAX_SLIPS    (MAX_SLIPS),
      .ERR_WIDTH    (ERR_WIDTH)
    ) u_lane (
      .CLKDIV    (CLKDIV),
      .RST       (RST),
      .restart   (RESTART),
      .err_inject(ERR_INJECT[n]),
      .rx_data   (RX_DATA[lane_lsb(n, DATA_WIDTH) +: DATA_WIDTH]),
      .tx_data   (TX_DATA[lane_lsb(n, DATA_WIDTH) +: DATA_WIDTH]),
      .bitslip   (BITSLIP[n]),
      .locked    (LOCKED[n]),
      .fail      (FAIL[n]),
      .err_count (ERR_COUNT[lane_lsb(n, ERR_WIDTH) +: ERR_WIDTH]),
      .state_dbg (STATE_DBG[lane_lsb(n, STATE_W) +: STATE_W])
    );
  end

  always_ff @(posedge CLKDIV) begin
    if (RST) ALL_LOCKED <= 1'b0;
    else     ALL_LOCKED <= &LOCKED;
  end

endmodule

// File: tb/tb_serdes_link_aligner.sv
// Directed bench for serdes_link_aligner: per-lane rotating loopback with a
// 2-cycle slip latency, plus a narrow-counter instance for saturation.
module tb_serdes_link_aligner;
  import serdes_link_pkg::*;

  localparam int         NC    = 4;
  localparam int         DW    = 8;
  localparam int         EW    = 16;
  localparam int         SEW   = 4;
  localparam logic [7:0] TRAIN = 8'h2C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, restart;
  logic [NC-1:0]        err_inject;
  logic [NC*DW-1:0]     tx_data, rx_data;
  logic [NC-1:0]        bitslip, locked, fail;
  logic                 all_locked;
  logic [NC*EW-1:0]     err_count;
  logic [NC*STATE_W-1:0] state_dbg;

  logic                  sat_restart, corrupt;
  logic [NC-1:0]         sat_err_inject;
  logic [NC*DW-1:0]      sat_tx, sat_rx;
  logic [NC-1:0]         sat_bitslip, sat_locked, sat_fail;
  logic                  sat_all_locked;
  logic [NC*SEW-1:0]     sat_err;
  logic [NC*STATE_W-1:0] sat_state;

  serdes_link_aligner #(.MATCH_COUNT(4)) dut (
    .CLKDIV(clk), .RST(rst), .RESTART(restart), .ERR_INJECT(err_inject),
    .TX_DATA(tx_data), .RX_DATA(rx_data), .BITSLIP(bitslip), .LOCKED(locked),
    .FAIL(fail), .ALL_LOCKED(all_locked), .ERR_COUNT(err_count), .STATE_DBG(state_dbg)
  );

  serdes_link_aligner #(.MATCH_COUNT(4), .ERR_WIDTH(SEW)) dut_sat (
    .CLKDIV(clk), .RST(rst), .RESTART(sat_restart), .ERR_INJECT(sat_err_inject),
    .TX_DATA(sat_tx), .RX_DATA(sat_rx), .BITSLIP(sat_bitslip), .LOCKED(sat_locked),
    .FAIL(sat_fail), .ALL_LOCKED(sat_all_locked), .ERR_COUNT(sat_err), .STATE_DBG(sat_state)
  );

  // ---------------- loopback model ----------------
  int            offset[NC]    = '{default: 0};
  int            slips[NC]     = '{default: 0};
  logic [NC-1:0] sl_d1         = '0;
  logic [NC-1:0] force_zero    = '0;
  int            pulse_cnt[NC] = '{default: 0};
  int            b2b_cnt       = 0;
  logic [NC-1:0] prev_bs       = '0;

  function automatic logic [7:0] rotl8(input logic [7:0] w, input int s);
    int r;
    logic [7:0] o;
    r = ((s % 8) + 8) % 8;
    o = '0;
    for (int i = 0; i < 8; i++) o[(i + r) % 8] = w[i];
    return o;
  endfunction

  always_comb begin
    rx_data = '0;
    for (int n = 0; n < NC; n++)
      rx_data[n*DW +: DW] = force_zero[n] ? 8'h00 : rotl8(tx_data[n*DW +: DW], slips[n] - offset[n]);
  end

  assign sat_rx = corrupt ? ~sat_tx : sat_tx;

  always @(posedge clk) begin
    if (rst) begin
      sl_d1 <= '0;
      for (int n = 0; n < NC; n++) slips[n] <= 0;
    end else begin
      sl_d1 <= bitslip;
      for (int n = 0; n < NC; n++) if (sl_d1[n]) slips[n] <= slips[n] + 1;
    end
  end

  always @(negedge clk) begin
    for (int n = 0; n < NC; n++) if (bitslip[n]) pulse_cnt[n]++;
    if ((bitslip & prev_bs) != '0) b2b_cnt++;
    prev_bs = bitslip;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  int cyc;
  int lock_cyc[NC];
  int fail_cyc[NC];
  int snap[NC];
  int all_cyc;

  // Called at a negedge; RST is held for two edges with RESTART and
  // ERR_INJECT also high so the override is exercised every time.
  task automatic hold_reset(input int o0, input int o1, input int o2, input int o3);
    offset[0] = o0; offset[1] = o1; offset[2] = o2; offset[3] = o3;
    rst = 1'b1; restart = 1'b1; err_inject = '1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic release_reset();
    rst = 1'b0; restart = 1'b0; err_inject = '0;
    cyc = -1; all_cyc = -1;
    for (int n = 0; n < NC; n++) begin
      lock_cyc[n] = -1; fail_cyc[n] = -1; snap[n] = pulse_cnt[n];
    end
  endtask

  // cyc 0 is the first rising edge with RST low; samples at the negedge.
  task automatic run_cycles(input int count);
    repeat (count) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int n = 0; n < NC; n++) begin
        if (lock_cyc[n] < 0 && locked[n]) lock_cyc[n] = cyc;
        if (fail_cyc[n] < 0 && fail[n])   fail_cyc[n] = cyc;
      end
      if (all_cyc < 0 && all_locked) all_cyc = cyc;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx"},      tx_data,    {NC{TRAIN}});
    check({tag, "_bitslip"}, bitslip,    '0);
    check({tag, "_locked"},  locked,     '0);
    check({tag, "_fail"},    fail,       '0);
    check({tag, "_all"},     all_locked, '0);
    check({tag, "_err"},     err_count,  '0);
    check({tag, "_state"},   state_dbg,  '0);
    check({tag, "_sat_err"}, sat_err,    '0);
    check({tag, "_sat_st"},  {sat_state, sat_bitslip, sat_locked}, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    rst = 1'b1; restart = 1'b0; err_inject = '0;
    sat_restart = 1'b0; sat_err_inject = '0; corrupt = 1'b0;
    @(negedge clk);

    // 1: zero offsets, no slips
    hold_reset(0, 0, 0, 0);
    check_reset("t1_rst");
    release_reset();
    run_cycles(12);
    for (int n = 0; n < NC; n++) check("t1_lock_cyc", lock_cyc[n], 8);
    check("t1_all_cyc", all_cyc, 9);
    check("t1_locked", locked, 4'hF);
    check("t1_err", err_count, '0);
    for (int n = 0; n < NC; n++) check("t1_pulses", pulse_cnt[n] - snap[n], 0);

    // 2: offsets 3,0,7,1
    hold_reset(3, 0, 7, 1);
    release_reset();
    run_cycles(60);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(7); exp_q.push_back(1);
    for (int n = 0; n < NC; n++) check("t2_pulses", pulse_cnt[n] - snap[n], exp_q.pop_front());
    check("t2_lock0", lock_cyc[0], 26);
    check("t2_lock1", lock_cyc[1], 8);
    check("t2_lock2", lock_cyc[2], 50);
    check("t2_lock3", lock_cyc[3], 14);
    check("t2_all_cyc", all_cyc, 51);
    check("t2_fail", fail, '0);

    // 3: lane 1 never aligns
    force_zero = 4'b0010;
    hold_reset(0, 0, 0, 0);
    release_reset();
    run_cycles(70);
    check("t3_pulses1", pulse_cnt[1] - snap[1], 8);
    check("t3_fail_cyc", fail_cyc[1], 53);
    check("t3_fail", fail, 4'b0010);
    check("t3_locked", locked, 4'b1101);
    check("t3_all", all_locked, 1'b0);
    check("t3_all_cyc", all_cyc, -1);
    check("t3_state1", state_dbg[1*STATE_W +: STATE_W], ST_FAIL);

    // 4: error injection on lane 2 while locked
    force_zero = '0;
    hold_reset(0, 0, 0, 0);
    release_reset();
    run_cycles(12);
    repeat (3) begin
      err_inject = 4'b0100;
      run_cycles(1);
      check("t4_tx2", tx_data[2*DW +: DW], 8'h2D);
      err_inject = '0;
      run_cycles(3);
    end
    check("t4_err", err_count, 64'h0000_0003_0000_0000);
    check("t4_locked", locked, 4'hF);

    // 5: saturation on the 4-bit counter instance
    check("t5_sat_pre", sat_err, '0);
    corrupt = 1'b1;
    run_cycles(20);
    check("t5_sat_err", sat_err, 16'hFFFF);
    check("t5_sat_locked", {sat_all_locked, sat_locked}, 5'b11111);
    check("t5_sat_fail", sat_fail, '0);
    corrupt = 1'b0;

    // 6: restart on a SLIP cycle, then reset while waiting
    hold_reset(5, 0, 0, 0);
    release_reset();
    run_cycles(10);
    err_inject = 4'b1000;
    run_cycles(1);
    err_inject = '0;
    run_cycles(3);
    check("t6_err3", err_count, 64'h0001_0000_0000_0000);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (state_dbg[0 +: STATE_W] == ST_SLIP) found = 1'b1;
      else run_cycles(1);
    end
    check("t6_slip_seen", found, 1'b1);
    check("t6_pre_pulses", pulse_cnt[0] - snap[0], 2);
    snap[0] = pulse_cnt[0];
    restart = 1'b1;
    run_cycles(1);
    restart = 1'b0;
    check("t6_rs_err", err_count, '0);
    check("t6_rs_state", state_dbg, '0);
    check("t6_rs_bs", bitslip, 4'b0001);
    run_cycles(1);
    check("t6_rs_locked", locked, '0);
    check("t6_rs_bs2", bitslip, '0);
    check("t6_rs_pulses", pulse_cnt[0] - snap[0], 1);
    hold_reset(5, 0, 0, 0);
    check_reset("t6_rst");
    release_reset();
    run_cycles(45);
    check("t6_pulses0", pulse_cnt[0] - snap[0], 5);
    check("t6_lock0", lock_cyc[0], 38);
    check("t6_lock3", lock_cyc[3], 8);
    check("t6_all_cyc", all_cyc, 39);
    check("t6_fail", fail, '0);

    check("b2b_pulses", b2b_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serdes_link_aligner.md
Name: serdes_link_aligner

Overview:
- Multi-channel word-alignment and link-check engine for OSERDESE2/ISERDESE2 loopback test designs.
- Drives a fixed training word into each channel's OSERDES parallel inputs.
- Steers each channel's ISERDES BITSLIP until the received word matches the training word, then counts bit errors while locked.
- Sits entirely in the CLKDIV (word-rate) domain, between the SERDES primitives and test status outputs.

Parameters:
- NUM_CHANNELS, 4, number of independent SERDES lanes.
- DATA_WIDTH, 8, parallel word width per lane (2..8; 10/14 not supported).
- TRAIN_PATTERN, 8'h2C, training word. All DATA_WIDTH rotations must be distinct; a periodic pattern is illegal.
- SLIP_WAIT, 4, CLKDIV cycles ignored after reset, restart or a BITSLIP pulse, covering ISERDES slip latency.
- MATCH_COUNT, 16, consecutive matching words required to declare lock (≥1).
- MAX_SLIPS, DATA_WIDTH, slips attempted before declaring failure.
- ERR_WIDTH, 16, per-lane error counter width.

Ports:
- CLKDIV  input  1  word-rate clock; all logic is on its rising edge.
- RST  input  1  synchronous, active-high reset.
- RESTART  input  1  single-cycle request to re-run alignment on all lanes.
- ERR_INJECT  input  NUM_CHANNELS  per-lane single-cycle error injection.
- TX_DATA  output  NUM_CHANNELS*DATA_WIDTH  registered words to the OSERDES D inputs; lane n at [n*DATA_WIDTH +: DATA_WIDTH].
- RX_DATA  input  NUM_CHANNELS*DATA_WIDTH  ISERDES Q words, same packing; bit DATA_WIDTH-1 is the first received bit.
- BITSLIP  output  NUM_CHANNELS  one-cycle slip pulses to the ISERDES.
- LOCKED  output  NUM_CHANNELS  lane aligned.
- FAIL  output  NUM_CHANNELS  lane exhausted MAX_SLIPS without lock; sticky.
- ALL_LOCKED  output  1  AND of LOCKED.
- ERR_COUNT  output  NUM_CHANNELS*ERR_WIDTH  saturating mismatch count per lane while locked.

Behaviour:
Reset state
- RST high at a clock edge puts every lane in WAIT.
- Cleared at reset: wait counter, slip counter, match counter, error counter.
- Output reset values: BITSLIP=0, LOCKED=0, FAIL=0, ALL_LOCKED=0, ERR_COUNT=0, TX_DATA=TRAIN_PATTERN on every lane.
- RST overrides RESTART and ERR_INJECT.

TX path
- TX_DATA lane n is registered each cycle.
- Next value is TRAIN_PATTERN, XOR 1 on bit 0 when ERR_INJECT[n] is high that cycle.
- Latency from ERR_INJECT to TX_DATA is 1 cycle.

Per-lane FSM (states WAIT, CHECK, SLIP, LOCKED, FAIL)
- WAIT: stay SLIP_WAIT cycles, RX ignored, then go to CHECK.
- CHECK: compare RX_DATA to TRAIN_PATTERN.
  - Match: increment the match counter. The cycle in which the count reaches MATCH_COUNT goes to LOCKED.
  - Mismatch with slip counter < MAX_SLIPS: clear the match counter and go to SLIP.
  - Mismatch with slip counter = MAX_SLIPS: go to FAIL.
- SLIP: BITSLIP high for exactly this one cycle, increment the slip counter, go to WAIT.
- LOCKED: LOCKED=1.
  - Each RX mismatch increments ERR_COUNT by 1, saturating at all-ones.
  - The lane does not leave LOCKED on errors.
- FAIL: FAIL=1; stays until RESTART or RST.

RESTART
- Any state goes to WAIT with all lane counters cleared, including ERR_COUNT.
- LOCKED and FAIL drop in the next cycle.
- RESTART arriving during a SLIP cycle does not extend or repeat the pulse.

Lock timing
- LOCKED, FAIL and BITSLIP are registered FSM decodes.
- With k slips needed (k ≤ MAX_SLIPS), LOCKED rises k*(SLIP_WAIT+2)+SLIP_WAIT+MATCH_COUNT cycles after the first edge with RST low.
- No pulse is emitted when k=0.

Independence and outputs
- Lanes are independent; ALL_LOCKED is registered, one cycle behind the last LOCKED.
- BITSLIP is never high two consecutive cycles on a lane.

Decomposition:
- Package serdes_link_pkg holds:
  - the state encoding (WAIT, CHECK, SLIP, LOCKED, FAIL);
  - clog2-based width constants for the wait, slip and match counters;
  - the lane-slice helper for packed buses.
- Sub-module serdes_link_lane: one FSM, counters, TX register and error counter.
- The top generates NUM_CHANNELS lane instances plus the ALL_LOCKED register.

Test Plan:
- Bench model is a per-lane loopback that left-rotates RX by the slip count, with a 2-cycle slip latency. Parameters are default with MATCH_COUNT=4.
1. Offset 0 on all lanes → no BITSLIP pulses; LOCKED=4'hF at cycle 8; ALL_LOCKED=1 at cycle 9; ERR_COUNT=0.
2. Lane offsets 3,0,7,1 → BITSLIP pulse counts 3,0,7,1; lane 2 LOCKED at cycle 7*6+8=50; ALL_LOCKED one cycle after lane 2.
3. Lane 1 RX forced to 8'h00 → 8 pulses on lane 1, then FAIL[1]=1 and LOCKED[1]=0. Other lanes lock normally; ALL_LOCKED stays 0.
4. All lanes locked, ERR_INJECT=4'b0100 for 3 separate cycles → ERR_COUNT lane 2 = 3; other lanes 0.
5. ERR_WIDTH=4, RX corrupted continuously after lock → ERR_COUNT saturates at 4'hF and LOCKED stays 1.
6. RESTART mid-slip on lane with offset 5, then RST asserted during WAIT → counters and outputs return to reset values; realignment completes with exactly 5 further pulses after RST release.
